tlul_simple_host: RTL
=====================

# tlul_simple_host

TileLink-UL (TL-UL) host adapter that turns a simple request/grant register-access port into TL-UL A-channel transactions and returns D-channel responses as a read-data/error strobe. It is the initiator counterpart to the peripheral register blocks, such as the GPIO register top. Self-test and bring-up logic use it to drive any TL-UL device through the 102-bit h2d and 68-bit d2h packed buses. It supports up to `MaxOutstanding` in-order transactions and checks response source IDs.

## Interface
- `MaxOutstanding`, default 2, maximum number of in-flight transactions (1..8); sets the depth of the source-ID FIFO.
- `SourceBase`, default 8'h00, base value for `a_source`; the low `$clog2(MaxOutstanding)` bits are replaced by a rolling ID.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_i` input 1: access request.
- `gnt_o` output 1: request accepted this cycle.
- `we_i` input 1: 1 = write, 0 = read.
- `addr_i` input 32: byte address; bits [1:0] are forced to 0 on the bus.
- `wdata_i` input 32: write data.
- `be_i` input 4: byte enables.
- `rvalid_o` output 1: response strobe.
- `rdata_o` output 32: read data.
- `err_o` output 1: response error, qualified by `rvalid_o`.
- `spurious_o` output 1: one-cycle pulse on a D beat with no transaction outstanding.
- `tl_o` output 102: h2d bus. Fields, MSB first:
  - a_valid [101], a_opcode [100:98], a_param [97:95], a_size [94:93].
  - a_source [92:85], a_address [84:53], a_mask [52:49], a_data [48:17].
  - a_user [16:1], d_ready [0].
- `tl_i` input 68: d2h bus. Fields, MSB first:
  - d_valid [67], d_opcode [66:64], d_param [63:61], d_size [60:59].
  - d_source [58:51], d_sink [50], d_data [49:18], d_user [17:2].
  - d_error [1], a_ready [0].

## Operation
- **Grant:** `gnt_o = req_i & ~a_valid_q & (outstanding < MaxOutstanding)`. The grant is combinational and never depends on `a_ready`.
- **Capture on grant:** the A register is loaded with:
  - opcode: Get (4) when `we_i=0`; PutFullData (0) when `we_i=1` and `be_i=4'hF`; PutPartialData (1) otherwise.
  - mask: `be_i` for writes, 4'hF for reads.
  - data: `wdata_i` for writes, 0 for reads.
  - address: `{addr_i[31:2],2'b00}`.
  - fixed fields: param 0, size 2, user 16'h0.
  - source: `SourceBase` with the low bits replaced by `id_q`.
- **After capture:** `id_q` increments, modulo `MaxOutstanding`, and the source is pushed into the ID FIFO.
- **A channel:** `a_valid_q` stays high, with all A fields stable, until a cycle where `a_ready=1`. It clears on that cycle.
- **d_ready:** tied to 1; the host never back-pressures.
- **Outstanding counter:** increments on grant and decrements on a D beat (`d_valid` with outstanding>0). A grant and a D beat in the same cycle leave it unchanged.
- **D beat handling** (outstanding>0): pop the FIFO, then register the response:
  - `rvalid_o=1`.
  - `rdata_o = d_data` if d_opcode=AccessAckData (1), else 0.
  - `err_o = d_error | (d_source != FIFO head) | (d_opcode ∉ {0,1}) | (opcode mismatch)`. Opcode mismatch means a read expected AccessAckData or a write expected AccessAck; the FIFO stores the we bit beside the ID.
- **D beat with outstanding=0:** `spurious_o` pulses, no FIFO pop, no `rvalid_o`.
- **Response order:** in-order only; responses are returned in grant order.

## Timing
- **Reset values:**
  - a_valid_q=0, with all other `tl_o` fields 0 except d_ready=1.
  - `gnt_o` follows its formula; with no request it is 0.
  - rvalid_o=0, rdata_o=0, err_o=0, spurious_o=0.
  - outstanding=0, id_q=0, FIFO empty.
- **Request to bus:** a grant at cycle N gives `a_valid=1` at N+1. The earliest next grant is the cycle after `a_ready` is seen, so back-to-back throughput is one request every 2 cycles.
- **Response latency:** D beat at cycle M gives `rvalid_o`/`rdata_o`/`err_o` at M+1, held for exactly one cycle. `rdata_o` holds its value until the next response.
- **Same-cycle response:** a D beat in the same cycle as `a_ready` of the same transaction is legal. The counter goes +1 at grant, −1 at the D beat.
- **Reset mid-operation:** asynchronously clears all state. In-flight transactions are abandoned; late D beats after reset raise `spurious_o`.

## Test plan
- **Single read:** req, we=0, addr=0x0000_000C.
  - Expect gnt same cycle, then `tl_o` at the next cycle: a_valid=1, opcode=4, mask=F, source=0x00.
  - Device answers AccessAckData, data=0xDEAD_BEEF, source=0x00 → rvalid_o=1, rdata_o=0xDEAD_BEEF, err_o=0.
- **Partial write:** we=1, be=4'b0011, wdata=0x1234_5678, addr=0x17.
  - Expect opcode=1, address=0x14, mask=3.
  - AccessAck response → rvalid_o=1, rdata_o=0, err_o=0.
- **Back-pressure:**
  - Hold a_ready=0 for 5 cycles → a_valid and all A fields stable, gnt_o=0 throughout.
  - a_ready=1 → a_valid drops the next cycle.
- **Outstanding limit** (MaxOutstanding=2):
  - Issue 3 reads with no responses → third gnt_o stays 0.
  - One response → third granted next eligible cycle, with source=0x00 again after wrap.
- **Error checks:**
  - Response with d_source=0x05 while FIFO head is 0x01 → err_o=1.
  - d_error=1 → err_o=1.
  - AccessAck to a read → err_o=1.
- **Spurious and reset:**
  - D beat with nothing outstanding → spurious_o pulses 1 cycle, no rvalid_o.
  - rst_ni low while 2 transactions outstanding → outstanding=0; a later D beat raises spurious_o.

Source files
------------

// File: rtl/tlul_simple_host_if.sv
// Register-access port plus packed TL-UL h2d/d2h buses for tlul_simple_host.
// The master modport is the side that issues requests and plays the TL-UL device; the slave modport is the host adapter.
interface tlul_simple_host_if;
  logic         req_i;
  logic         gnt_o;
  logic         we_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic [3:0]   be_i;
  logic         rvalid_o;
  logic [31:0]  rdata_o;
  logic         err_o;
  logic         spurious_o;
  logic [101:0] tl_o;
  logic [67:0]  tl_i;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, tl_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, spurious_o, tl_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, tl_i,
    output gnt_o, rvalid_o, rdata_o, err_o, spurious_o, tl_o
  );
endinterface

// File: rtl/tlul_simple_host.sv
// TL-UL host adapter: request/grant register port to A-channel, in-order D responses
// with source-ID, opcode and error checking against a small FIFO of issued requests.
module tlul_simple_host #(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [7:0]  SourceBase     = 8'h00
) (
  input logic                clk_i,
  input logic                rst_ni,
  tlul_simple_host_if.slave  bus
);
  localparam int unsigned IdW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [IdW-1:0]  LastId = IdW'(MaxOutstanding - 1);
  localparam logic [7:0]      IdMask = 8'((1 << $clog2(MaxOutstanding)) - 1);

  localparam logic [2:0] OpPutFull = 3'd0;
  localparam logic [2:0] OpPutPart = 3'd1;
  localparam logic [2:0] OpGet     = 3'd4;
  localparam logic [2:0] OpAckData = 3'd1;

  logic            r_a_valid;
  logic [2:0]      r_a_opcode;
  logic [1:0]      r_a_size;
  logic [7:0]      r_a_source;
  logic [31:0]     r_a_address;
  logic [3:0]      r_a_mask;
  logic [31:0]     r_a_data;
  logic [IdW-1:0]  r_id;
  logic [IdW-1:0]  r_rd;
  logic [CntW-1:0] r_outstanding;
  logic [8:0]      r_fifo [MaxOutstanding];
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            r_spurious;

  logic        w_a_ready, w_d_valid, w_d_error;
  logic [2:0]  w_d_opcode;
  logic [7:0]  w_d_source;
  logic [31:0] w_d_data;
  logic        w_gnt, w_beat, w_resp_err;
  logic [7:0]  w_src;
  logic [8:0]  w_head;
  logic        w_unused_d;

  assign w_a_ready  = bus.tl_i[0];
  assign w_d_error  = bus.tl_i[1];
  assign w_d_data   = bus.tl_i[49:18];
  assign w_d_source = bus.tl_i[58:51];
  assign w_d_opcode = bus.tl_i[66:64];
  assign w_d_valid  = bus.tl_i[67];
  assign w_unused_d = ^{bus.tl_i[63:59], bus.tl_i[50], bus.tl_i[17:2]};

  assign w_gnt  = bus.req_i & ~r_a_valid & (r_outstanding < MaxCnt);
  assign w_beat = w_d_valid & (r_outstanding != '0);
  assign w_src  = (SourceBase & ~IdMask) | {{(8 - IdW){1'b0}}, r_id};
  assign w_head = r_fifo[r_rd];

  // FIFO entry is {we, source}; a read must see AccessAckData, a write AccessAck.
  assign w_resp_err = w_d_error | (w_d_source != w_head[7:0]) | (w_d_opcode[2:1] != 2'b00)
                    | (w_d_opcode[0] == w_head[8]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a_valid     <= 1'b0;
      r_a_opcode    <= '0;
      r_a_size      <= '0;
      r_a_source    <= '0;
      r_a_address   <= '0;
      r_a_mask      <= '0;
      r_a_data      <= '0;
      r_id          <= '0;
      r_rd          <= '0;
      r_outstanding <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) r_fifo[i] <= '0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_spurious    <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_a_valid   <= 1'b1;
        r_a_opcode  <= !bus.we_i ? OpGet : (bus.be_i == 4'hF) ? OpPutFull : OpPutPart;
        r_a_size    <= 2'd2;
        r_a_source  <= w_src;
        r_a_address <= {bus.addr_i[31:2], 2'b00};
        r_a_mask    <= bus.we_i ? bus.be_i : 4'hF;
        r_a_data    <= bus.we_i ? bus.wdata_i : 32'h0;
        r_fifo[r_id] <= {bus.we_i, w_src};
        r_id        <= (r_id == LastId) ? '0 : r_id + 1'b1;
      end else if (r_a_valid && w_a_ready) begin
        r_a_valid <= 1'b0;
      end

      case ({w_gnt, w_beat})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      r_rvalid   <= w_beat;
      r_err      <= w_beat & w_resp_err;
      r_spurious <= w_d_valid & (r_outstanding == '0);
      if (w_beat) begin
        r_rdata <= (w_d_opcode == OpAckData) ? w_d_data : 32'h0;
        r_rd    <= (r_rd == LastId) ? '0 : r_rd + 1'b1;
      end
    end
  end

  assign bus.gnt_o      = w_gnt;
  assign bus.rvalid_o   = r_rvalid;
  assign bus.rdata_o    = r_rdata;
  assign bus.err_o      = r_err;
  assign bus.spurious_o = r_spurious;
  assign bus.tl_o = {r_a_valid, r_a_opcode, 3'b000, r_a_size, r_a_source, r_a_address,
                     r_a_mask, r_a_data, 16'h0000, 1'b1};
endmodule
